// File: rtl/biphasemark_encode.sv
// Biphase-mark transmitter: serialises stereo PCM pairs into S/PDIF-style
// subframes (8 preamble half-bits + 28 BMC-coded data bits = 64 half-bits).
module biphasemark_encode #(
    parameter int HALFBIT_DIV      = 4,
    parameter int FRAMES_PER_BLOCK = 192,
    parameter int SAMPLE_W         = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                vin,
    output logic                in_ready,
    output logic                dout,
    output logic                vout,
    output logic [7:0]          frame_counter,
    output logic                channel
);
    localparam int DW = (HALFBIT_DIV > 1) ? $clog2(HALFBIT_DIV) : 1;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic [DW-1:0]       div;
    logic                tick;
    logic [5:0]          idx;
    logic                started;
    logic                buf_full;
    logic [SAMPLE_W-1:0] buf_l, buf_r;
    logic [7:0]          pre;
    logic [27:0]         sh;
    logic [27:0]         sh_r;

    logic                new_ch;
    logic [7:0]          fc_next;
    logic [7:0]          pat;
    logic                consume;
    logic [27:0]         lword, rword;

    // 28-bit subframe payload, LSB first: audio[23:0], V, U=0, C=0, P (even parity)
    function automatic logic [27:0] mk_word(input logic [SAMPLE_W-1:0] s, input logic v);
        logic [23:0] a;
        a = 24'(s);
        return {^{a, v}, 2'b00, v, a};
    endfunction

    assign tick     = (div == DW'(HALFBIT_DIV - 1));
    assign in_ready = ~buf_full;

    // Decisions taken at the start of the next subframe (idx 0 tick)
    always_comb begin
        new_ch  = started ? ~channel : 1'b0;
        fc_next = frame_counter;
        if (started && channel)
            fc_next = (frame_counter == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_counter + 8'd1;
        if (new_ch)
            pat = PRE_W;
        else if (fc_next == 8'd0)
            pat = PRE_B;
        else
            pat = PRE_M;
        // preamble polarity follows the current line level
        pat     = pat ^ {8{dout}};
        consume = tick && (idx == 6'd0) && !new_ch;
        lword   = buf_full ? mk_word(buf_l, 1'b0) : mk_word('0, 1'b1);
        rword   = buf_full ? mk_word(buf_r, 1'b0) : mk_word('0, 1'b1);
    end

    // Half-bit tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    // One-entry pair buffer; a load is never bypassed into the current frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
        end else if (vin && !buf_full) begin
            buf_full <= 1'b1;
            buf_l    <= left_in;
            buf_r    <= right_in;
        end else if (consume) begin
            buf_full <= 1'b0;
        end
    end

    // Subframe sequencer, preamble shifter and BMC line encoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            started       <= 1'b0;
            channel       <= 1'b0;
            frame_counter <= '0;
            pre           <= '0;
            sh            <= '0;
            sh_r          <= '0;
            dout          <= 1'b0;
            vout          <= 1'b0;
        end else begin
            vout <= tick;
            if (tick) begin
                idx <= idx + 6'd1;
                if (idx == 6'd0) begin
                    started       <= 1'b1;
                    channel       <= new_ch;
                    frame_counter <= fc_next;
                    dout          <= pat[7];
                    pre           <= {pat[6:0], 1'b0};
                    if (!new_ch) begin
                        sh   <= lword;
                        sh_r <= rword;
                    end else begin
                        sh <= sh_r;
                    end
                end else if (idx < 6'd8) begin
                    dout <= pre[7];
                    pre  <= {pre[6:0], 1'b0};
                end else if (!idx[0]) begin
                    // first half of a data bit always transitions
                    dout <= ~dout;
                end else begin
                    // second half transitions again only for a 1
                    dout <= dout ^ sh[0];
                    sh   <= {1'b0, sh[27:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_biphasemark_encode.sv
// Scoreboard bench: stimulus pushes the expected half-bit stream per subframe,
// a monitor pops and compares on every vout strobe.
module tb_biphasemark_encode;
    localparam int DIV = 4;
    localparam int FPB = 4;
    localparam int NP  = 2 * FPB + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] left_in, right_in;
    logic        vin;
    logic        in_ready, dout, vout, channel;
    logic [7:0]  frame_counter;

    biphasemark_encode #(.HALFBIT_DIV(DIV), .FRAMES_PER_BLOCK(FPB), .SAMPLE_W(24)) dut (
        .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in), .vin(vin),
        .in_ready(in_ready), .dout(dout), .vout(vout),
        .frame_counter(frame_counter), .channel(channel)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   nhb   = 0;
    int   sess  = 1;
    int   cyc   = 0;
    int   last_cyc = 0;
    logic mlev  = 1'b0;
    logic q[$];
    logic cap[10];

    logic [23:0] pl[NP] = '{24'h000001, 24'hA5A5A5, 24'hFFFFFF, 24'h123456, 24'h800000,
                            24'h7FFFFF, 24'h00F00F, 24'hA5A5A5, 24'h000003, 24'h555555};
    logic [23:0] pr[NP] = '{24'h000000, 24'h5A5A5A, 24'h000000, 24'h654321, 24'h000001,
                            24'hFFFFFE, 24'hF00F00, 24'h5A5A5A, 24'hC00000, 24'hAAAAAA};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected half-bits of one subframe; sel 0=B 1=M 2=W
    task automatic push_sub(input int sel, input logic [23:0] a, input logic v);
        logic [7:0]  p;
        logic [27:0] w;
        logic        f, s;
        p = (sel == 0) ? 8'b11101000 : (sel == 1) ? 8'b11100010 : 8'b11100100;
        if (mlev) p = ~p;
        for (int i = 7; i >= 0; i--) q.push_back(p[i]);
        mlev = p[0];
        w = {^{a, v}, 2'b00, v, a};
        for (int k = 0; k < 28; k++) begin
            f = ~mlev;
            s = f ^ w[k];
            q.push_back(f);
            q.push_back(s);
            mlev = s;
        end
    endtask

    task automatic push_frame(input int f, input logic [23:0] l, input logic [23:0] r, input logic v);
        push_sub((f % FPB == 0) ? 0 : 1, l, v);
        push_sub(2, r, v);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe pops one expected half-bit
    always @(negedge clk) begin
        if (!rst && vout) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(nhb), 32'hFFFF_FFFF);
            end else begin
                chk("dout", 32'(dout), 32'(q.pop_front()));
            end
            if (nhb > 0) chk("strobe_spacing", 32'(cyc - last_cyc), 32'(DIV));
            if (nhb % 64 == 0 || nhb % 64 == 40) begin
                chk("channel", 32'(channel), 32'((nhb / 64) % 2));
                chk("frame_counter", 32'(frame_counter), 32'(((nhb / 64) / 2) % FPB));
            end
            if (sess == 2 && nhb % 64 == 0) chk("in_ready_underrun", 32'(in_ready), 32'd1);
            if (nhb < 10) cap[nhb] = dout;
            last_cyc = cyc;
            nhb++;
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk(name, 32'(in_ready), 32'd1);
    endtask

    task automatic load_pair(input logic [23:0] l, input logic [23:0] r);
        vin = 1'b1; left_in = l; right_in = r;
        @(negedge clk);
        vin = 1'b0; left_in = '0; right_in = '0;
    endtask

    initial begin
        logic [9:0] first10;
        int         n;
        rst = 1'b1; vin = 1'b0; left_in = '0; right_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_fc", 32'(frame_counter), 32'd0);
        chk("rst_channel", 32'(channel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // session 1: pair ready before the first tick, continuous feeding
        rst = 1'b0;
        push_frame(0, pl[0], pr[0], 1'b0);
        load_pair(pl[0], pr[0]);
        chk("in_ready_after_load", 32'(in_ready), 32'd0);
        for (int i = 1; i < NP; i++) begin
            wait_ready("wait_in_ready");
            push_frame(i, pl[i], pr[i], 1'b0);
            load_pair(pl[i], pr[i]);
        end

        // reach half-bit 30 of the right subframe of frame NP-2
        n = 0;
        while (nhb < (2 * (NP - 2) + 1) * 64 + 31 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reach_midreset_point", 32'(nhb >= (2 * (NP - 2) + 1) * 64 + 31), 32'd1);
        for (int i = 0; i < 10; i++) first10[9 - i] = cap[i];
        chk("first10_B_bit0", 32'(first10), 32'(10'b1110100010));

        #1 rst = 1'b1;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_vout", 32'(vout), 32'd0);
        chk("midrst_fc", 32'(frame_counter), 32'd0);
        chk("midrst_channel", 32'(channel), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        // session 2: buffered pair discarded, no feeding -> underrun frames
        q.delete();
        nhb  = 0;
        sess = 2;
        mlev = 1'b0;
        push_frame(0, 24'h0, 24'h0, 1'b1);
        push_frame(1, 24'h0, 24'h0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        for (int i = 0; i < 10; i++) first10[9 - i] = cap[i];
        chk("first10_underrun", 32'(first10), 32'(10'b1110100011));
        chk("in_ready_end", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
